pipe_fetch_issue: RTL

- Upstream neighbour of the 4-stage ALU/writeback pipeline; produces the per-cycle rs1, rs2, rd, func and addr operand fields that pipeline consumes.
- Fetches 24-bit instruction words from an external synchronous instruction memory and buffers them in a small FIFO.
- Decodes the FIFO head and holds issue with bubbles while a read-after-write hazard is open against the downstream register bank.
- Stops on a HALT instruction.

---
 rtl/pipe_fetch_issue.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_fetch_issue.sv
// pipe_fetch_issue: fetches 24-bit instruction words from a synchronous instruction
// memory into a small FIFO, decodes the FIFO head and issues one operand slot per
// cycle, inserting bubbles while a read-after-write hazard is open downstream.
// Optional performance counters are built only when PIPE_FETCH_PERF_EN is defined.
module pipe_fetch_issue #(
    parameter int PC_W       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int HAZARD_WIN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    output logic            imem_rd,
    output logic [PC_W-1:0] imem_addr,
    input  logic [23:0]     imem_data,
    output logic            issue_valid,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [3:0]      rd,
    output logic [3:0]      func,
    output logic [7:0]      addr,
    output logic            halted,
    output logic            err_illegal,
    output logic [15:0]     issue_count,
    output logic [15:0]     stall_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [PC_W-1:0]                pc_q, pc_d;
    logic                           inflight_q;
    logic [23:0]                    fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]               wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]               fifoCount_q;
    logic [HAZARD_WIN-1:0]          sbValid_q;
    logic [HAZARD_WIN-1:0][3:0]     sbRd_q;

    logic                           issueValid_q;
    logic [3:0]                     func_q, rd_q, rs1_q, rs2_q;
    logic [7:0]                     addr_q;
    logic                           errIllegal_q;

    logic [23:0]                    headWord;
    logic [3:0]                     headFunc, headRd, headRs1, headRs2;
    logic                           fifoEmpty;
    logic                           fifoPush;
    logic                           hazard;
    logic                           doPop, doIssue, doIllegal, doHalt, fetchReq;

    assign headWord  = fifoMem_q[rdPtr_q];
    assign headFunc  = headWord[23:20];
    assign headRd    = headWord[19:16];
    assign headRs1   = headWord[15:12];
    assign headRs2   = headWord[11:8];
    assign fifoEmpty = (fifoCount_q == '0);
    // A response that lands in the same cycle a HALT is decoded belongs to the
    // abandoned stream and is dropped along with the flushed FIFO.
    assign fifoPush  = inflight_q && !doHalt;

    // Head source register collides with any recently issued destination.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZARD_WIN; i++) begin
            if (sbValid_q[i] && (sbRd_q[i] == headRs1 || sbRd_q[i] == headRs2)) begin
                hazard = 1'b1;
            end
        end
    end

    // Next-state, decode/issue decision and fetch request for this cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        doPop     = 1'b0;
        doIssue   = 1'b0;
        doIllegal = 1'b0;
        doHalt    = 1'b0;
        fetchReq  = 1'b0;
        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = start_pc;
                end
            end
            RUN: begin
                if (!fifoEmpty) begin
                    if (headFunc >= 4'd12 && headFunc <= 4'd14) begin
                        doPop     = 1'b1;
                        doIllegal = 1'b1;
                    end else if (headFunc == 4'd15) begin
                        doPop   = 1'b1;
                        doHalt  = 1'b1;
                        state_d = HALTED;
                    end else if (!hazard) begin
                        doPop   = 1'b1;
                        doIssue = 1'b1;
                    end
                end
                // Counting the in-flight word keeps a returning response from
                // ever landing in a full FIFO; no new fetch once HALT is seen.
                fetchReq = !doHalt && ((fifoCount_q + CNT_W'(inflight_q)) < DEPTH_C);
                if (fetchReq) begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_rd   = fetchReq;
    assign imem_addr = pc_q;
    assign halted    = (state_q == HALTED);

    // Control state, fetch pointer and outstanding-request flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= fetchReq;
        end
    end

    // FIFO occupancy and pointers; a HALT empties the buffer outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else if (doHalt) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (fifoPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            fifoCount_q <= fifoCount_q + CNT_W'(fifoPush) - CNT_W'(doPop);
        end
    end

    // FIFO storage; contents are meaningless until counted valid, so no reset.
    always_ff @(posedge clk) begin
        if (fifoPush) begin
            fifoMem_q[wrPtr_q] <= imem_data;
        end
    end

    // Registered issue slot; every field reads zero on a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issueValid_q <= 1'b0;
            func_q       <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            addr_q       <= '0;
            errIllegal_q <= 1'b0;
        end else begin
            issueValid_q <= doIssue;
            func_q       <= doIssue ? headFunc : 4'd0;
            rd_q         <= doIssue ? headRd : 4'd0;
            rs1_q        <= doIssue ? headRs1 : 4'd0;
            rs2_q        <= doIssue ? headRs2 : 4'd0;
            addr_q       <= doIssue ? headWord[7:0] : 8'd0;
            errIllegal_q <= errIllegal_q | doIllegal;
        end
    end

    assign issue_valid = issueValid_q;
    assign func        = func_q;
    assign rd          = rd_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign addr        = addr_q;
    assign err_illegal = errIllegal_q;

    // Scoreboard of the last HAZARD_WIN issue slots, advanced every RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbValid_q <= '0;
            sbRd_q    <= '0;
        end else if (state_q == RUN) begin
            for (int i = HAZARD_WIN - 1; i > 0; i--) begin
                sbValid_q[i] <= sbValid_q[i-1];
                sbRd_q[i]    <= sbRd_q[i-1];
            end
            sbValid_q[0] <= doIssue;
            sbRd_q[0]    <= headRd;
        end
    end

`ifdef PIPE_FETCH_PERF_EN
    logic [15:0] issueCnt_q, stallCnt_q;
    logic        hazardStall;
    logic        startAccept;

    assign hazardStall = (state_q == RUN) && !fifoEmpty && (headFunc < 4'd12) && hazard;
    assign startAccept = start && (state_q != RUN);

    // Saturating issue and hazard-stall counters, restarted by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issueCnt_q <= '0;
            stallCnt_q <= '0;
        end else if (startAccept) begin
            issueCnt_q <= '0;
            stallCnt_q <= '0;
        end else begin
            if (doIssue && issueCnt_q != 16'hFFFF) begin
                issueCnt_q <= issueCnt_q + 16'd1;
            end
            if (hazardStall && stallCnt_q != 16'hFFFF) begin
                stallCnt_q <= stallCnt_q + 16'd1;
            end
        end
    end

    assign issue_count = issueCnt_q;
    assign stall_count = stallCnt_q;
`else
    assign issue_count = 16'd0;
    assign stall_count = 16'd0;
`endif

endmodule
